// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared loader state encoding and default geometry constants,
//               also consumed by the CPU top level.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int unsigned c_width      = 12;
    localparam int unsigned c_addr_width = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FINISH = 3'd2,
        RUN    = 3'd3,
        ERROR  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_xor_accum.sv
`default_nettype none
// ============================================================================
// Module      : xor_accum
// Description : WIDTH-bit running XOR with synchronous clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_accum #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc ^ din;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Streams a boot image into instruction memory while holding the
//               CPU in reset. Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WIDTH      = c_width,
    parameter int ADDR_WIDTH = c_addr_width
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [WIDTH-1:0]      imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [ADDR_WIDTH:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [WIDTH-1:0]      r_wdata;

    logic                  w_hs;
    logic                  w_write;
    logic                  w_start_load;
    logic [ADDR_WIDTH:0]   w_count_inc;

    assign w_hs         = s_valid && (r_state == LOAD);
    assign w_start_load = start && ((r_state == IDLE) || (r_state == RUN) || (r_state == ERROR));
    assign w_count_inc  = r_count + (ADDR_WIDTH+1)'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] w_xor;

    // The checksum word is consumed by the comparison only; data words feed the XOR.
    assign w_write = w_hs && !s_last;

    xor_accum #(
        .WIDTH (WIDTH)
    ) u_xor_accum (
        .clk   (clk),
        .reset (reset),
        .clr   (w_start_load),
        .en    (w_write),
        .din   (s_data),
        .acc   (w_xor)
    );
`else
    assign w_write = w_hs;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = LOAD;
            end
            LOAD: begin
                if (w_hs) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (s_last)
                        w_state_nxt = (s_data == w_xor) ? FINISH : ERROR;
                    else if (w_count_inc == c_depth)
                        w_state_nxt = ERROR;
`else
                    // A last word landing exactly on DEPTH is legal; only a
                    // non-final word there would wrap the address.
                    if (s_last)
                        w_state_nxt = FINISH;
                    else if (w_count_inc == c_depth)
                        w_state_nxt = ERROR;
`endif
                end
            end
            FINISH: w_state_nxt = RUN;
            RUN, ERROR: begin
                if (start) w_state_nxt = LOAD;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_write;
            if (w_write) begin
                r_waddr <= r_addr;
                r_wdata <= s_data;
                r_addr  <= r_addr + ADDR_WIDTH'(1);
                r_count <= w_count_inc;
            end
            if (w_start_load) begin
                r_addr  <= '0;
                r_count <= '0;
            end
        end
    end

    assign s_ready    = (r_state == LOAD);
    assign busy       = (r_state == LOAD) || (r_state == FINISH);
    assign done       = (r_state == RUN);
    assign error      = (r_state == ERROR);
    assign cpu_reset  = (r_state != RUN);
    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign word_count = r_count;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the pipelined CPU's instruction memory. It accepts a valid/ready stream of 12-bit instruction words and writes them to consecutive instruction-memory addresses starting at 0. While loading, it holds the CPU core in reset, and it releases the core once the final word is committed. Overflow and (optionally) checksum faults park the block in an error state with the core still held.

## Interface
Parameters:
- WIDTH, 12, instruction word width; matches the CPU instruction/PC width
- ADDR_WIDTH, 8, instruction-memory address width; DEPTH = 2**ADDR_WIDTH words

Ports:
- clk  input  1  single clock for all state
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin or restart a load
- s_valid  input  1  stream word valid
- s_data  input  WIDTH  stream instruction word
- s_last  input  1  marks the final word of the image; qualified by s_valid
- s_ready  output  1  loader accepts a word this cycle
- imem_we  output  1  instruction-memory write strobe
- imem_waddr  output  ADDR_WIDTH  write address
- imem_wdata  output  WIDTH  write data
- cpu_reset  output  1  active-high reset to the CPU core
- busy  output  1  high in LOAD and FINISH
- done  output  1  high in RUN
- error  output  1  high in ERROR
- word_count  output  ADDR_WIDTH+1  words written in the current or last load

## Operation
- States: IDLE, LOAD, FINISH, RUN, ERROR.
- Reset values: state=IDLE, cpu_reset=1, s_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, error=0, word_count=0.
- A handshake occurs when s_valid && s_ready on a rising clk edge. s_ready=1 only in LOAD.
- IDLE: cpu_reset=1. start → LOAD. The address counter and word_count clear to 0.
- LOAD, on each handshake:
  - Register a write of s_data to the current address.
  - Increment the address (mod DEPTH) and word_count.
  - If s_last → FINISH.
  - Else, if word_count reaches DEPTH → ERROR, because the address would wrap.
  - A handshake with s_last on word DEPTH is legal and goes → FINISH.
- FINISH: one cycle. → RUN.
- RUN: cpu_reset=0, done=1. start → LOAD, which reasserts cpu_reset on the next cycle and clears the counters.
- ERROR: cpu_reset=1, error=1. Only start (→ LOAD) or reset exits this state.
- start while in LOAD or FINISH is ignored.
- start together with s_valid in IDLE/RUN/ERROR: no word is accepted that cycle, because s_ready=0.
- An asynchronous reset mid-load returns to IDLE immediately. Words already written are not erased.
- s_data, s_last and s_valid are ignored while s_ready=0.

## Timing
- Write latency: a handshake at edge N drives imem_we=1 with imem_waddr/imem_wdata during cycle N+1. imem_we is a one-cycle pulse per accepted word.
- Throughput: one word per cycle while s_valid stays high.
- Final handshake at edge N:
  - FINISH during cycle N+1, with the final write.
  - RUN from edge N+2: cpu_reset=0 and done=1 during cycle N+2 onward.
- start sampled at edge M: busy=1, s_ready=1, cpu_reset=1 during cycle M+1.
- Overflow handshake at edge N: the write completes in cycle N+1 and error=1 from cycle N+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The word flagged s_last is a checksum, not an instruction. It is not written and not counted.
  - The loader compares it against the running XOR of all written words (WIDTH bits, reset to 0 on start).
  - Match → FINISH. Mismatch → ERROR in the next cycle.
  - The overflow rule applies only to data words.
- Undefined: no checksum logic; the s_last word is written like any other word.

## Structure
- Shared package `imem_loader_pkg` contains:
  - the state enum (IDLE=0, LOAD=1, FINISH=2, RUN=3, ERROR=4, 3-bit encoding);
  - the default WIDTH/ADDR_WIDTH constants, shared with the CPU top level.
- One sub-module, `xor_accum`: WIDTH-bit running XOR with a synchronous clear and an enable. It is instantiated only under IMEM_LOADER_CHECKSUM_EN.
- The FSM, address counter and write register live in the top module.

## Test plan
- Reset, then start, then 4 back-to-back words 0x001, 0x202, 0x4C5, 0xE1F (last on the 4th):
  - writes to addresses 0–3 in consecutive cycles;
  - word_count=4;
  - cpu_reset falls 2 cycles after the last handshake, with done=1.
- Same 4 words with s_valid deasserted for 3 cycles between words 2 and 3: no spurious imem_we; addresses stay contiguous.
- ADDR_WIDTH=4: stream 16 words without s_last → error=1 after the 16th write, s_ready=0, cpu_reset stays 1. A subsequent start recovers to LOAD.
- Drop reset low for one cycle in the middle of word 2 → IDLE, cpu_reset=1, word_count=0. A new start reloads from address 0.
- Apply start while in RUN → cpu_reset=1 the next cycle and the address restarts at 0.
- With IMEM_LOADER_CHECKSUM_EN: data 0x00F, 0x0F0, then checksum 0x0FF → RUN with word_count=2. The same stream with checksum 0x0FE → ERROR, and only 2 writes are issued.
